// File: rtl/branch_resolve_sched.sv
// Barrel-core PC sequencer: round-robin fetch issue, tagged retire
// through the branch_logic latency, per-hart PC update.
module branch_resolve_sched #(
  parameter int          NUM_HARTS   = 16,
  parameter int          HART_W      = $clog2(NUM_HARTS),
  parameter int          PIPE_STAGE0 = 0,
  parameter int          PIPE_STAGE1 = 0,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] i_hart_en,
  output logic                 o_fetch_valid,
  output logic [HART_W-1:0]    o_fetch_hart,
  output logic [31:0]          o_fetch_pc,
  input  logic                 i_ex_valid,
  input  logic [HART_W-1:0]    i_ex_hart,
  input  logic [31:0]          i_ex_pc,
  input  logic [31:0]          i_ex_target,
  input  logic                 i_ex_is_jump,
  input  logic                 i_is_branch_valid,
  output logic                 o_redirect,
  output logic                 o_err_spurious
);

  localparam int LAT = PIPE_STAGE0 + PIPE_STAGE1;

  typedef struct packed {
    logic              v;
    logic [HART_W-1:0] h;
    logic [31:0]       pc;
    logic [31:0]       tgt;
    logic              j;
  } tag_t;

  tag_t w_tag_in;
  tag_t w_tag;

  logic [31:0]          r_pc [NUM_HARTS];
  logic [NUM_HARTS-1:0] r_pending;
  logic [HART_W-1:0]    r_rr_ptr;
  logic                 r_fetch_valid;
  logic [HART_W-1:0]    r_fetch_hart;
  logic [31:0]          r_fetch_pc;
  logic                 r_redirect;
  logic                 r_err;

  logic [NUM_HARTS-1:0] w_elig;
  logic                 w_found;
  logic [HART_W-1:0]    w_grant;
  logic                 w_taken;
  logic [31:0]          w_npc;
  logic [NUM_HARTS-1:0] w_pend_nxt;

  assign w_tag_in = '{v: i_ex_valid, h: i_ex_hart, pc: i_ex_pc,
                      tgt: i_ex_target, j: i_ex_is_jump};

  generate
    if (LAT == 0) begin : g_comb
      assign w_tag = w_tag_in;
    end else begin : g_line
      tag_t r_line [LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < LAT; k++) r_line[k] <= '0;
        end else begin
          r_line[0] <= w_tag_in;
          for (int k = 1; k < LAT; k++) r_line[k] <= r_line[k-1];
        end
      end
      assign w_tag = r_line[LAT-1];
    end
  endgenerate

  assign w_elig = i_hart_en & ~r_pending;

  always_comb begin
    w_found = 1'b0;
    w_grant = r_rr_ptr;
    for (int i = 0; i < NUM_HARTS; i++) begin
      logic [HART_W-1:0] idx;
      idx = r_rr_ptr + HART_W'(i);
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign w_taken = w_tag.j | i_is_branch_valid;
  assign w_npc   = w_taken ? (w_tag.tgt & ~32'h1) : w_tag.pc + 32'd4;

  // Retire clears before issue sets; issue only sees pre-edge pending.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_tag.v) w_pend_nxt[w_tag.h] = 1'b0;
    if (w_found) w_pend_nxt[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_HARTS; k++) r_pc[k] <= RESET_PC;
      r_pending     <= '0;
      r_rr_ptr      <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_hart  <= '0;
      r_fetch_pc    <= '0;
      r_redirect    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_found) begin
        r_fetch_valid <= 1'b1;
        r_fetch_hart  <= w_grant;
        r_fetch_pc    <= r_pc[w_grant];
        r_rr_ptr      <= w_grant + 1'b1;
      end else begin
        r_fetch_valid <= 1'b0;
      end
      r_redirect <= w_tag.v & w_taken;
      if (w_tag.v) begin
        r_pc[w_tag.h] <= w_npc;
        if (!r_pending[w_tag.h]) r_err <= 1'b1;
      end
      r_pending <= w_pend_nxt;
    end
  end

  assign o_fetch_valid  = r_fetch_valid;
  assign o_fetch_hart   = r_fetch_hart;
  assign o_fetch_pc     = r_fetch_pc;
  assign o_redirect     = r_redirect;
  assign o_err_spurious = r_err;

endmodule

// File: tb/tb_branch_resolve_sched.sv
// Directed bench for branch_resolve_sched, two-cycle branch latency.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_branch_resolve_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hart_en;
  logic        f_valid;
  logic [3:0]  f_hart;
  logic [31:0] f_pc;
  logic        ex_valid;
  logic [3:0]  ex_hart;
  logic [31:0] ex_pc;
  logic [31:0] ex_tgt;
  logic        ex_jump;
  logic        bv;
  logic        redir;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_sched #(
    .NUM_HARTS(16), .PIPE_STAGE0(1), .PIPE_STAGE1(1), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_hart_en(hart_en),
    .o_fetch_valid(f_valid), .o_fetch_hart(f_hart), .o_fetch_pc(f_pc),
    .i_ex_valid(ex_valid), .i_ex_hart(ex_hart), .i_ex_pc(ex_pc),
    .i_ex_target(ex_tgt), .i_ex_is_jump(ex_jump),
    .i_is_branch_valid(bv), .o_redirect(redir), .o_err_spurious(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [3:0] h,
                       input logic [31:0] p);
    chk({tag, "_v"}, 32'(f_valid), 32'd1);
    chk({tag, "_h"}, 32'(f_hart), 32'(h));
    chk({tag, "_pc"}, f_pc, p);
  endtask

  // Launch one instruction; returns just after its retire edge.
  task automatic retire(input logic [3:0] h, input logic [31:0] p,
                        input logic [31:0] t, input logic j,
                        input logic b);
    ex_valid = 1'b1; ex_hart = h; ex_pc = p; ex_tgt = t; ex_jump = j;
    tick();
    ex_valid = 1'b0; ex_hart = '0; ex_pc = '0; ex_tgt = '0; ex_jump = 0;
    tick();
    bv = b;
    tick();
    bv = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hart_en = 16'hFFFF; bv = 1'b0;
    ex_valid = 1'b0; ex_hart = '0; ex_pc = '0; ex_tgt = '0; ex_jump = 0;
    tick();
    chk("rst_valid", 32'(f_valid), 32'd0);
    chk("rst_redir", 32'(redir), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick();
      fetch($sformatf("rr%0d", i), 4'(i), 32'h0);
    end
    tick();
    chk("rr_idle", 32'(f_valid), 32'd0);

    retire(4'd3, 32'h100, 32'h0, 1'b0, 1'b0);
    chk("nt_redir", 32'(redir), 32'd0);
    chk("nt_noissue", 32'(f_valid), 32'd0);
    tick();
    fetch("nt_reissue", 4'd3, 32'h104);
    tick();
    chk("nt_idle", 32'(f_valid), 32'd0);

    retire(4'd5, 32'h500, 32'h2001, 1'b0, 1'b1);
    chk("tk_redir", 32'(redir), 32'd1);
    tick();
    chk("tk_pulse", 32'(redir), 32'd0);
    fetch("tk_reissue", 4'd5, 32'h2000);

    retire(4'd3, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    chk("wrap_redir", 32'(redir), 32'd0);
    tick();
    fetch("wrap_pc", 4'd3, 32'h0);

    retire(4'd3, 32'h0, 32'h303, 1'b1, 1'b0);
    chk("jmp_redir", 32'(redir), 32'd1);
    tick();
    fetch("jmp_pc", 4'd3, 32'h302);

    hart_en = 16'hFF7F;
    retire(4'd7, 32'h700, 32'h0, 1'b0, 1'b0);
    chk("dis_err", 32'(err), 32'd0);
    tick();
    chk("dis_noissue", 32'(f_valid), 32'd0);
    retire(4'd7, 32'h704, 32'h0, 1'b0, 1'b0);
    chk("spur_err", 32'(err), 32'd1);
    tick();
    tick();
    chk("spur_sticky", 32'(err), 32'd1);

    ex_valid = 1'b1; ex_hart = 4'd2; ex_pc = 32'h200;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(f_valid), 32'd0);
    chk("arst_hart", 32'(f_hart), 32'd0);
    chk("arst_pc", f_pc, 32'd0);
    chk("arst_redir", 32'(redir), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    ex_valid = 1'b0; ex_hart = '0; ex_pc = '0;
    hart_en = 16'h0001;
    tick();
    rst_n = 1'b1;

    tick();
    fetch("p2_h0", 4'd0, 32'h0);
    tick();
    chk("p2_idle", 32'(f_valid), 32'd0);
    tick();
    chk("p2_noerr", 32'(err), 32'd0);
    chk("p2_noredir", 32'(redir), 32'd0);
    hart_en = 16'h0011;
    tick();
    fetch("p2_h4", 4'd4, 32'h0);
    retire(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("p2_busy", 32'(f_valid), 32'd0);
    tick();
    fetch("p2_wrap_h0", 4'd0, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
